// File: rtl/regfile_write_arbiter_if.sv
// Requester / register-file bus for the write arbiter.
// The master side is the requesters plus the register file; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              hold;
  logic [2:0]        req_valid;
  logic [ADDR_W-1:0] req_reg0;
  logic [ADDR_W-1:0] req_reg1;
  logic [ADDR_W-1:0] req_reg2;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [DATA_W-1:0] req_data2;
  logic [2:0]        req_ready;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [1:0]        grant_id;
  logic [3:0]        busy_mask;

  modport master (
    output hold, req_valid, req_reg0, req_reg1, req_reg2,
           req_data0, req_data1, req_data2,
    input  req_ready, rf_write, rf_write_reg, rf_write_data, grant_id, busy_mask
  );

  modport slave (
    input  hold, req_valid, req_reg0, req_reg1, req_reg2,
           req_data0, req_data1, req_data2,
    output req_ready, rf_write, rf_write_reg, rf_write_data, grant_id, busy_mask
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging three register-file write sources (ALU, load, debug)
// into a single registered write port. One grant per cycle; the granted write
// appears on rf_* the following cycle.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  logic [1:0]        ptr;
  logic [2:0]        grant;
  logic [1:0]        grant_idx;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              rf_write_q;
  logic [ADDR_W-1:0] rf_write_reg_q;
  logic [DATA_W-1:0] rf_write_data_q;
  logic [1:0]        grant_id_q;
  logic [3:0]        busy_q;

  // Pick the first valid requester starting at ptr; suppressed by hold or reset.
  always_comb begin
    logic [2:0] idx;
    grant     = 3'b000;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    idx       = 3'd0;
    for (int k = 0; k < 3; k++) begin
      idx = 3'(ptr) + 3'(k);
      if (idx > 3'd2) idx = idx - 3'd3;
      if (!grant_any && bus.req_valid[idx[1:0]]) begin
        grant[idx[1:0]] = 1'b1;
        grant_idx       = idx[1:0];
        grant_any       = 1'b1;
      end
    end
    if (!reset || bus.hold) begin
      grant     = 3'b000;
      grant_any = 1'b0;
    end
  end

  // Steer the granted requester's target and data into the output register.
  always_comb begin
    sel_reg  = bus.req_reg0;
    sel_data = bus.req_data0;
    case (grant_idx)
      2'd1: begin
        sel_reg  = bus.req_reg1;
        sel_data = bus.req_data1;
      end
      2'd2: begin
        sel_reg  = bus.req_reg2;
        sel_data = bus.req_data2;
      end
      default: begin
        sel_reg  = bus.req_reg0;
        sel_data = bus.req_data0;
      end
    endcase
  end

  // Register the accepted write and advance the priority pointer past the winner.
  // Target/data/id are only reloaded on a transfer so they hold across idle cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_write_q      <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      grant_id_q      <= 2'd0;
      ptr             <= 2'd0;
    end else begin
      rf_write_q <= grant_any;
      if (grant_any) begin
        rf_write_reg_q  <= sel_reg;
        rf_write_data_q <= sel_data;
        grant_id_q      <= grant_idx;
        ptr             <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
    end
  end

  // Decode the busy mask purely from the registered write port.
  always_comb begin
    busy_q = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      busy_q[r] = rf_write_q && (rf_write_reg_q == ADDR_W'(r));
    end
  end

  assign bus.req_ready     = grant;
  assign bus.rf_write      = rf_write_q;
  assign bus.rf_write_reg  = rf_write_reg_q;
  assign bus.rf_write_data = rf_write_data_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.busy_mask     = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for the register-file write arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  bit [2:0]   v_valid;
  bit [1:0]   v_reg [3];
  bit [7:0]   v_data[3];

  int         m_ptr;
  bit         m_write;
  int         m_reg;
  int         m_data;
  int         m_gid;
  int         last_g;
  logic [2:0] obs_ready;
  int         waitc[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Round-robin choice: first valid requester in order ptr, ptr+1, ptr+2 (mod 3).
  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (v_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check the combinational grant, clock, check registered outputs.
  task automatic step(input bit r, input bit h);
    int         g;
    logic [2:0] exp_ready;
    logic [3:0] exp_busy;
    reset         = r;
    bus.hold      = h;
    bus.req_valid = v_valid;
    bus.req_reg0  = v_reg[0];
    bus.req_reg1  = v_reg[1];
    bus.req_reg2  = v_reg[2];
    bus.req_data0 = v_data[0];
    bus.req_data1 = v_data[1];
    bus.req_data2 = v_data[2];
    #1;
    g         = (r && !h) ? model_pick() : -1;
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    obs_ready = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    check("ready_subset", 32'(bus.req_ready & ~v_valid), 32'd0);
    @(posedge clk);
    #1;
    if (!r) begin
      m_write = 1'b0; m_reg = 0; m_data = 0; m_gid = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_write = 1'b1; m_reg = v_reg[g]; m_data = v_data[g]; m_gid = g; m_ptr = (g + 1) % 3;
    end else begin
      m_write = 1'b0;
    end
    last_g   = g;
    exp_busy = m_write ? 4'(1 << m_reg) : 4'b0000;
    check("rf_write", 32'(bus.rf_write), 32'(m_write));
    check("rf_write_reg", 32'(bus.rf_write_reg), 32'(m_reg));
    check("rf_write_data", 32'(bus.rf_write_data), 32'(m_data));
    check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check("busy_mask", 32'(bus.busy_mask), 32'(exp_busy));
  endtask

  initial begin
    logic [2:0] rr_seq[6];
    bit         r;
    bit         h;
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    reset   = 1'b0;
    v_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      v_reg[i] = 2'd0; v_data[i] = 8'd0; waitc[i] = 0;
    end
    bus.hold = 1'b0; bus.req_valid = 3'b000;
    bus.req_reg0 = '0; bus.req_reg1 = '0; bus.req_reg2 = '0;
    bus.req_data0 = '0; bus.req_data1 = '0; bus.req_data2 = '0;
    m_ptr = 0; m_write = 1'b0; m_reg = 0; m_data = 0; m_gid = 0; last_g = -1;
    @(posedge clk);
    #1;

    // Reset state, with traffic present to show reset dominates
    v_valid = 3'b111;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("reset_busy", 32'(bus.busy_mask), 32'd0);

    // Single write from requester 0
    v_valid = 3'b001; v_reg[0] = 2'd2; v_data[0] = 8'h5A;
    step(1'b1, 1'b0);
    check("single_ready", 32'(obs_ready), 32'b001);
    check("single_data", 32'(bus.rf_write_data), 32'h5A);
    check("single_busy", 32'(bus.busy_mask), 32'b0100);

    // Round-robin with all three requesting continuously
    v_valid = 3'b000;
    step(1'b0, 1'b0);
    v_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      v_reg[i] = 2'($urandom); v_data[i] = 8'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      check("rr_seq", 32'(obs_ready), 32'(rr_seq[i]));
      check("rr_write", 32'(bus.rf_write), 32'd1);
    end

    // Same-register conflict: later grant wins
    v_valid = 3'b000;
    step(1'b0, 1'b0);
    v_valid = 3'b011;
    v_reg[0] = 2'd3; v_data[0] = 8'h11;
    v_reg[1] = 2'd3; v_data[1] = 8'h22;
    step(1'b1, 1'b0);
    check("conflict_first", 32'(bus.rf_write_data), 32'h11);
    v_valid = 3'b010;
    step(1'b1, 1'b0);
    check("conflict_second", 32'(bus.rf_write_data), 32'h22);
    v_valid = 3'b000;
    step(1'b1, 1'b0);
    check("conflict_final", 32'(bus.rf_write_data), 32'h22);

    // Hold blocks grants, then releases
    v_valid = 3'b010; v_data[1] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("hold_ready", 32'(obs_ready), 32'd0);
      check("hold_write", 32'(bus.rf_write), 32'd0);
    end
    step(1'b1, 1'b0);
    check("hold_release", 32'(obs_ready), 32'b010);
    check("hold_write_after", 32'(bus.rf_write), 32'd1);

    // Reset mid-operation discards the pending write
    v_valid = 3'b001;
    step(1'b1, 1'b0);
    v_valid = 3'b110;
    step(1'b0, 1'b0);
    check("midrst_write", 32'(bus.rf_write), 32'd0);
    check("midrst_busy", 32'(bus.busy_mask), 32'd0);
    check("midrst_gid", 32'(bus.grant_id), 32'd0);
    step(1'b1, 1'b0);
    check("midrst_first", 32'(obs_ready), 32'b010);

    // Randomized traffic with hold and occasional reset
    v_valid = 3'b000;
    step(1'b0, 1'b0);
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v_valid[i] && $urandom_range(0, 1) == 1) begin
          v_valid[i] = 1'b1;
          v_reg[i]   = 2'($urandom);
          v_data[i]  = 8'($urandom);
        end
      end
      r = ($urandom_range(0, 39) != 0);
      h = ($urandom_range(0, 4) == 0);
      step(r, h);
      for (int i = 0; i < 3; i++) begin
        if (!r) waitc[i] = 0;
        else if (v_valid[i] && !h) waitc[i]++;
        if (last_g == i) begin
          check("fairness", 32'(waitc[i] <= 3), 32'd1);
          waitc[i]   = 0;
          v_valid[i] = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
